mux_2to1_arbiter: RTL and testbench

Round-robin arbiter that shares one N-bit `mux_2to1` select path between two requesters (X and Y), each with a valid/ready handshake. The block drives the mux select C from its grant decision and captures the winning operand into a one-entry output register with its own valid/ready handshake toward the downstream ALU stage. It sits in front of the ALU operand input, replacing direct hard-wiring of C.

---
 rtl/mux_2to1_arbiter.sv | 112 +++++++++++
 tb/tb_mux_2to1_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mux_2to1_arbiter.sv
// rtl/mux_2to1_arbiter.sv - round-robin arbiter sharing one mux_2to1 select path between two requesters
// Drives mux select C from the grant and registers the winning operand for the ALU stage.

module mux_2to1 #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sel,
  output logic [N-1:0] y
);

  assign y = sel ? b : a;

endmodule

module mux_2to1_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         X_valid,
  input  logic [N-1:0] X,
  output logic         X_ready,
  input  logic         Y_valid,
  input  logic [N-1:0] Y,
  output logic         Y_ready,
  output logic         R_valid,
  output logic [N-1:0] R,
  output logic         R_src,
  input  logic         R_ready,
  output logic         C
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t       state;
  state_t       state_next;
  logic         last;
  logic         c_q;
  logic         load_en;
  logic         grant_vld;
  logic         grant_y;
  logic [N-1:0] r_next;
  logic [N-1:0] r_q;
  logic         r_src_q;

  mux_2to1 #(.N(N)) u_mux (
    .a   (X),
    .b   (Y),
    .sel (C),
    .y   (r_next)
  );

  // Grant depends only on valids, register state and the priority pointer, never on data.
  always_comb begin
    load_en   = (state == EMPTY) || R_ready;
    grant_vld = 1'b0;
    grant_y   = c_q;
    if (!rst && load_en) begin
      if (X_valid && Y_valid) begin
        grant_vld = 1'b1;
        grant_y   = !last;
      end else if (Y_valid) begin
        grant_vld = 1'b1;
        grant_y   = 1'b1;
      end else if (X_valid) begin
        grant_vld = 1'b1;
        grant_y   = 1'b0;
      end
    end
  end

  always_comb begin
    state_next = state;
    if (grant_vld) begin
      state_next = FULL;
    end else if ((state == FULL) && R_ready) begin
      state_next = EMPTY;
    end
  end

  assign C       = grant_y;
  assign X_ready = grant_vld && !grant_y;
  assign Y_ready = grant_vld && grant_y;
  assign R_valid = (state == FULL);
  assign R       = r_q;
  assign R_src   = r_src_q;

  // last resets to Y so that X wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      r_q     <= '0;
      r_src_q <= 1'b0;
      last    <= 1'b1;
      c_q     <= 1'b0;
    end else begin
      state <= state_next;
      if (grant_vld) begin
        r_q     <= r_next;
        r_src_q <= grant_y;
        last    <= grant_y;
        c_q     <= grant_y;
      end
    end
  end

endmodule

// File: tb/tb_mux_2to1_arbiter.sv
// tb/tb_mux_2to1_arbiter.sv - directed self-checking bench for mux_2to1_arbiter

module tb_mux_2to1_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        X_valid;
  logic [31:0] X;
  logic        X_ready;
  logic        Y_valid;
  logic [31:0] Y;
  logic        Y_ready;
  logic        R_valid;
  logic [31:0] R;
  logic        R_src;
  logic        R_ready;
  logic        C;

  int nvec = 0;
  int nerr = 0;

  mux_2to1_arbiter #(.N(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .X_valid (X_valid),
    .X       (X),
    .X_ready (X_ready),
    .Y_valid (Y_valid),
    .Y       (Y),
    .Y_ready (Y_ready),
    .R_valid (R_valid),
    .R       (R),
    .R_src   (R_src),
    .R_ready (R_ready),
    .C       (C)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        exp_y;
    logic [31:0] exp_r;

    rst     = 1'b1;
    X_valid = 1'b1;
    Y_valid = 1'b1;
    X       = 32'h0000_00AA;
    Y       = 32'h2222_2222;
    R_ready = 1'b1;
    #2;
    chk("rst_rvalid", {31'b0, R_valid}, 32'd0);
    chk("rst_r", R, 32'd0);
    chk("rst_xready", {31'b0, X_ready}, 32'd0);
    chk("rst_yready", {31'b0, Y_ready}, 32'd0);
    chk("rst_c", {31'b0, C}, 32'd0);
    edge_step();
    edge_step();
    chk("rst_hold_rvalid", {31'b0, R_valid}, 32'd0);

    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("first_xready", {31'b0, X_ready}, 32'd1);
    chk("first_yready", {31'b0, Y_ready}, 32'd0);
    chk("first_c", {31'b0, C}, 32'd0);
    edge_step();
    chk("first_r", R, 32'h0000_00AA);
    chk("first_rsrc", {31'b0, R_src}, 32'd0);
    chk("first_rvalid", {31'b0, R_valid}, 32'd1);

    // Tie alternation: last transfer was X, so the sequence starts with Y.
    X = 32'h1111_1111;
    #1;
    for (int i = 0; i < 6; i++) begin
      exp_y = (i % 2 == 0);
      exp_r = exp_y ? 32'h2222_2222 : 32'h1111_1111;
      chk("tie_c", {31'b0, C}, {31'b0, exp_y});
      chk("tie_xready", {31'b0, X_ready}, {31'b0, !exp_y});
      chk("tie_yready", {31'b0, Y_ready}, {31'b0, exp_y});
      edge_step();
      chk("tie_r", R, exp_r);
      chk("tie_rsrc", {31'b0, R_src}, {31'b0, exp_y});
      chk("tie_rvalid", {31'b0, R_valid}, 32'd1);
    end

    // Backpressure while FULL with the X word.
    R_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_xready", {31'b0, X_ready}, 32'd0);
      chk("bp_yready", {31'b0, Y_ready}, 32'd0);
      edge_step();
      chk("bp_r", R, 32'h1111_1111);
      chk("bp_rsrc", {31'b0, R_src}, 32'd0);
      chk("bp_rvalid", {31'b0, R_valid}, 32'd1);
    end
    R_ready = 1'b1;
    #1;
    chk("bp_release_yready", {31'b0, Y_ready}, 32'd1);
    chk("bp_release_c", {31'b0, C}, 32'd1);
    edge_step();
    chk("bp_release_r", R, 32'h2222_2222);
    chk("bp_release_rvalid", {31'b0, R_valid}, 32'd1);
    chk("bp_release_rsrc", {31'b0, R_src}, 32'd1);

    // Single requester Y even though last is already Y.
    X_valid = 1'b0;
    Y       = 32'hDEAD_BEEF;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("single_yready", {31'b0, Y_ready}, 32'd1);
      chk("single_xready", {31'b0, X_ready}, 32'd0);
      chk("single_c", {31'b0, C}, 32'd1);
      edge_step();
      chk("single_r", R, 32'hDEAD_BEEF);
      chk("single_rsrc", {31'b0, R_src}, 32'd1);
    end

    // Drain to empty after Y: C holds 1.
    Y_valid = 1'b0;
    #1;
    chk("drain_y_c", {31'b0, C}, 32'd1);
    edge_step();
    chk("drain_y_rvalid", {31'b0, R_valid}, 32'd0);
    chk("drain_y_r", R, 32'hDEAD_BEEF);
    chk("drain_y_c_hold", {31'b0, C}, 32'd1);

    // One X transfer then drain: C holds 0, R keeps value.
    X_valid = 1'b1;
    X       = 32'h1234_5678;
    #1;
    chk("drain_x_xready", {31'b0, X_ready}, 32'd1);
    chk("drain_x_c", {31'b0, C}, 32'd0);
    edge_step();
    chk("drain_x_rvalid1", {31'b0, R_valid}, 32'd1);
    chk("drain_x_r1", R, 32'h1234_5678);
    X_valid = 1'b0;
    #1;
    chk("drain_x_noready", {31'b0, X_ready | Y_ready}, 32'd0);
    edge_step();
    chk("drain_x_rvalid0", {31'b0, R_valid}, 32'd0);
    chk("drain_x_r0", R, 32'h1234_5678);
    chk("drain_x_rsrc", {31'b0, R_src}, 32'd0);
    chk("drain_x_c_hold", {31'b0, C}, 32'd0);

    // Async reset between edges while FULL with Y data (last = Y).
    Y_valid = 1'b1;
    Y       = 32'hCAFE_F00D;
    edge_step();
    chk("mid_pre_rvalid", {31'b0, R_valid}, 32'd1);
    chk("mid_pre_r", R, 32'hCAFE_F00D);
    X_valid = 1'b1;
    R_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rvalid", {31'b0, R_valid}, 32'd0);
    chk("mid_r", R, 32'd0);
    chk("mid_rsrc", {31'b0, R_src}, 32'd0);
    chk("mid_c", {31'b0, C}, 32'd0);
    chk("mid_ready", {31'b0, X_ready | Y_ready}, 32'd0);

    // After release, last is back to Y so X wins the tie.
    @(negedge clk);
    rst     = 1'b0;
    R_ready = 1'b1;
    #1;
    chk("post_xready", {31'b0, X_ready}, 32'd1);
    chk("post_yready", {31'b0, Y_ready}, 32'd0);
    edge_step();
    chk("post_r", R, 32'h1234_5678);
    chk("post_rsrc", {31'b0, R_src}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
